// File: rtl/quant_gain_sched.sv
// Queues software gain updates from the gain register and writes them into the
// quantizer gain RAM only in the burst that follows a spectrum sync pulse.
module quant_gain_sched #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned GAIN_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          user_clk,
    input  logic                          user_rst_n,
    input  logic [31:0]                   reg_word,
    input  logic                          sync_in,
    input  logic                          ovf_clr,
    output logic                          gain_we,
    output logic [ADDR_W-1:0]             gain_addr,
    output logic [GAIN_W-1:0]             gain_data,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic [15:0]                   upd_count,
    output logic                          ovf_sticky,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_W + GAIN_W;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
    localparam logic [1:0] ST_DRAIN     = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;

    logic             armed_q;
    logic             tog_q;
    logic             commit_q;
    logic [ENT_W-1:0] cmt_ent_q;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PTR_W-1:0] burst_q;

    logic             pop;
    logic             push_ok;
    logic             ovf_set;
    logic             burst_last;

    // Bits outside the chan/gain/toggle fields are intentionally ignored.
    logic             unused_word;
    assign unused_word = ^reg_word;

    // Commit detect: the toggle history is only loaded (not compared) in the first cycle out of reset.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            armed_q   <= 1'b0;
            tog_q     <= 1'b0;
            commit_q  <= 1'b0;
            cmt_ent_q <= '0;
        end else begin
            armed_q   <= 1'b1;
            tog_q     <= reg_word[31];
            commit_q  <= armed_q && (reg_word[31] != tog_q);
            cmt_ent_q <= {reg_word[16+ADDR_W-1:16], reg_word[GAIN_W-1:0]};
        end
    end

    // Occupancy after this cycle's pop decides whether a push fits.
    always_comb begin
        pop        = (state_q == ST_DRAIN) && (cnt_q != '0);
        push_ok    = commit_q && ((cnt_q - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH));
        ovf_set    = commit_q && !push_ok;
        cnt_nxt    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        burst_last = (burst_q == PTR_W'(FIFO_DEPTH - 1));
    end

    always_ff @(posedge user_clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= cmt_ent_q;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            if (push_ok) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            if (state_q != ST_DRAIN) begin
                burst_q <= '0;
            end else if (pop) begin
                burst_q <= burst_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // A burst ends when the queue empties or after FIFO_DEPTH writes, whichever comes first.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    state_nxt = ST_WAIT_SYNC;
                end
            end
            ST_WAIT_SYNC: begin
                if (sync_in) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_nxt == '0) begin
                    state_nxt = ST_IDLE;
                end else if (burst_last) begin
                    state_nxt = ST_WAIT_SYNC;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // RAM write port and status outputs; addr/data hold between writes.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            gain_we    <= 1'b0;
            gain_addr  <= '0;
            gain_data  <= '0;
            upd_count  <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gain_we <= pop;
            if (pop) begin
                gain_addr <= mem_q[rd_q][ENT_W-1:GAIN_W];
                gain_data <= mem_q[rd_q][GAIN_W-1:0];
                upd_count <= upd_count + 16'd1;
            end
            if (ovf_set) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
            busy <= (state_nxt != ST_IDLE);
        end
    end

    assign pending = cnt_q;

endmodule

// File: tb/tb_quant_gain_sched.sv
// Scoreboard bench for quant_gain_sched: an abstract queue model predicts each
// RAM write; a monitor pops the expectation whenever gain_we is seen.
module tb_quant_gain_sched;

    localparam int DEPTH = 4;

    typedef logic [25:0] ent_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] reg_word;
    logic        sync_in;
    logic        ovf_clr;
    logic        gain_we;
    logic [9:0]  gain_addr;
    logic [15:0] gain_data;
    logic [2:0]  pending;
    logic [15:0] upd_count;
    logic        ovf_sticky;
    logic        busy;

    int   tests = 0;
    int   fails = 0;
    ent_t mq[$];
    ent_t exp_q[$];
    int   m_upd = 0;
    logic m_ovf = 1'b0;

    quant_gain_sched #(.ADDR_W(10), .GAIN_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .reg_word   (reg_word),
        .sync_in    (sync_in),
        .ovf_clr    (ovf_clr),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_data  (gain_data),
        .pending    (pending),
        .upd_count  (upd_count),
        .ovf_sticky (ovf_sticky),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every observed write must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n && gain_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected no write at %0t",
                         gain_addr, gain_data, $time);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("write_addr_data", 32'({gain_addr, gain_data}), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_word(input ent_t e);
        reg_word = {~reg_word[31], 5'($urandom), e};
    endtask

    function automatic ent_t rand_ent();
        return ent_t'({10'($urandom), 16'($urandom)});
    endfunction

    // One commit: queue it if there is room, otherwise it is lost and sticks the overflow flag.
    task automatic commit(input ent_t e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
        set_word(e);
        tick(1);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_pending"}, 32'(pending), 32'(mq.size()));
        check({tag, "_upd_count"}, 32'(upd_count), 32'(16'(m_upd)));
        check({tag, "_busy"}, 32'(busy), 32'(mq.size() != 0));
        check({tag, "_ovf"}, 32'(ovf_sticky), 32'(m_ovf));
    endtask

    // Sync pulse, optionally with n_join commits arriving during the burst's first cycles.
    // A burst writes everything queued plus the joiners, at most DEPTH entries.
    task automatic burst(input int n_join, input string tag);
        ent_t j[2];
        int   n, first, last, cnt;
        for (int i = 0; i < n_join; i++) begin
            j[i] = rand_ent();
            mq.push_back(j[i]);
        end
        n = (mq.size() < DEPTH) ? mq.size() : DEPTH;
        for (int i = 0; i < n; i++) exp_q.push_back(mq.pop_front());
        m_upd += n;
        sync_in = 1'b1;
        if (n_join > 0) set_word(j[0]);
        tick(1);
        sync_in = 1'b0;
        if (n_join > 1) set_word(j[1]);
        first = -1; last = -1; cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick(1);
            if (gain_we) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
            end
        end
        check({tag, "_write_count"}, 32'(cnt), 32'(n));
        if (n > 0) begin
            check({tag, "_first_latency"}, 32'(first), 32'd2);
            check({tag, "_back_to_back"}, 32'(last - first + 1), 32'(n));
        end
        check_status(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        reg_word = {1'b1, 31'($urandom)};
        sync_in  = 1'b0;
        ovf_clr  = 1'b0;
        tick(3);
        check("rst_gain_we", 32'(gain_we), 32'd0);
        check("rst_addr_data", 32'({gain_addr, gain_data}), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_upd_count", 32'(upd_count), 32'd0);
        check("rst_ovf", 32'(ovf_sticky), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Release with the toggle already high: history load only, no commit.
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("post_rst_no_we", 32'(gain_we), 32'd0);
        end
        check("post_rst_pending", 32'(pending), 32'd0);

        commit(ent_t'({10'd5, 16'h1234}));
        tick(4);
        burst(0, "single");

        // Overflow: five commits against a four-deep queue.
        for (int i = 0; i < 5; i++) commit(rand_ent());
        tick(4);
        check("ovf_set", 32'(ovf_sticky), 32'd1);
        check("ovf_pending", 32'(pending), 32'd4);
        burst(0, "full_burst");
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        tick(1);
        check("ovf_clr", 32'(ovf_sticky), 32'd0);

        // Commit together with sync while idle: not taken this spectrum.
        begin
            ent_t e;
            e = rand_ent();
            mq.push_back(e);
            set_word(e);
            sync_in = 1'b1;
            tick(1);
            sync_in = 1'b0;
            tick(8);
            check("idle_sync_pending", 32'(pending), 32'd1);
            check("idle_sync_upd", 32'(upd_count), 32'(16'(m_upd)));
            burst(0, "idle_sync_next");
        end

        // Joiner within a short burst; then a capped burst with leftovers.
        for (int i = 0; i < 2; i++) commit(rand_ent());
        tick(4);
        burst(1, "join");
        for (int i = 0; i < 4; i++) commit(rand_ent());
        tick(4);
        burst(2, "cap");
        check("cap_leftover", 32'(mq.size()), 32'd2);
        burst(0, "leftover");

        // Randomised rounds.
        for (int r = 0; r < 30; r++) begin
            int nc, nj;
            nc = $urandom_range(0, 6);
            for (int i = 0; i < nc; i++) begin
                commit(rand_ent());
                tick($urandom_range(0, 2));
            end
            tick(4);
            check("rnd_pre_pending", 32'(pending), 32'(mq.size()));
            check("rnd_pre_ovf", 32'(ovf_sticky), 32'(m_ovf));
            nj = (mq.size() > 0) ? $urandom_range(0, 2) : 0;
            burst(nj, "rnd");
            if ($urandom_range(0, 2) == 0) begin
                ovf_clr = 1'b1;
                tick(1);
                ovf_clr = 1'b0;
                m_ovf = 1'b0;
                tick(1);
                check("rnd_ovf_clr", 32'(ovf_sticky), 32'd0);
            end
        end

        // Reset in the middle of a four-write burst, after two writes.
        while (mq.size() > 0) burst(0, "flush");
        for (int i = 0; i < 4; i++) commit(rand_ent());
        tick(4);
        for (int i = 0; i < 4; i++) exp_q.push_back(mq.pop_front());
        sync_in = 1'b1;
        tick(1);
        sync_in = 1'b0;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gain_we", 32'(gain_we), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_upd_count", 32'(upd_count), 32'd0);
        check("mid_rst_writes_seen", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        mq.delete();
        m_upd = 0;
        m_ovf = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        burst(0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
